polar_sc_codec_n8: RTL and testbench

- Registered N=8 polar link-test block with three stages in one pipeline:
  - Polar encoder: frozen-bit insertion plus Arikan transform x = u·F⊗3.
  - BPSK mapper, producing signed LLR symbols.
  - Successive-cancellation (SC) min-sum decoder.
- Sits between a message source and a checker, for loopback/BER experiments.
- An external-LLR port lets noisy channel values replace the ideal BPSK symbols.

---
 rtl/polar_pkg.sv | 48 ++++
 rtl/polar_sc_codec_n8_if.sv | 25 ++
 rtl/polar_sc_dec8.sv | 50 +++++
 rtl/polar_sc_codec_n8.sv | 108 ++++++++++
 tb/tb_polar_sc_codec_n8.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/polar_pkg.sv
// Shared constants, LLR type and kernel helpers for the N=8 polar encoder / SC decoder.
package polar_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned SYM_W = 8;
    localparam int unsigned LLR_W = SYM_W + 3;

    typedef logic signed [LLR_W-1:0] llr_t;

    // Information positions per K, u1 in the MSB
    function automatic logic [N-1:0] info_mask(input int unsigned k);
        case (k)
            1:       return 8'b00000001;
            2:       return 8'b00000011;
            3:       return 8'b00000111;
            default: return 8'b00010111;
        endcase
    endfunction

    function automatic llr_t polar_f(input llr_t a, input llr_t b);
        llr_t abs_a;
        llr_t abs_b;
        llr_t mn;
        abs_a = a[LLR_W-1] ? -a : a;
        abs_b = b[LLR_W-1] ? -b : b;
        mn    = (abs_a < abs_b) ? abs_a : abs_b;
        return (a[LLR_W-1] ^ b[LLR_W-1]) ? -mn : mn;
    endfunction

    function automatic llr_t polar_g(input llr_t a, input llr_t b, input logic u);
        return u ? (b - a) : (b + a);
    endfunction

    // x_j collects every u_i whose index bits cover the bits of j
    function automatic logic [0:N-1] encode(input logic [0:N-1] u);
        logic [0:N-1] x;
        x = '0;
        for (int unsigned j = 0; j < N; j++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if ((i & j) == j) begin
                    x[j] = x[j] ^ u[i];
                end
            end
        end
        return x;
    endfunction

endpackage

// File: rtl/polar_sc_codec_n8_if.sv
// Message-in / codeword-and-decision-out bundle of the polar link-test block.
interface polar_sc_codec_n8_if #(
    parameter int unsigned K    = 4,
    parameter int unsigned SIZE = 8
);
    logic              in_valid;
    logic [0:K-1]      info_i;
    logic              llr_ext_en;
    logic [8*SIZE-1:0] llr_ext_i;
    logic [0:7]        codeword_o;
    logic [8*SIZE-1:0] sym_o;
    logic [0:7]        u_hat_o;
    logic [0:K-1]      info_o;
    logic              out_valid;

    modport master (
        output in_valid, info_i, llr_ext_en, llr_ext_i,
        input  codeword_o, sym_o, u_hat_o, info_o, out_valid
    );

    modport slave (
        input  in_valid, info_i, llr_ext_en, llr_ext_i,
        output codeword_o, sym_o, u_hat_o, info_o, out_valid
    );
endinterface

// File: rtl/polar_sc_dec8.sv
// Combinational min-sum successive-cancellation decoder for one N=8 polar block.
module polar_sc_dec8
    import polar_pkg::*;
(
    input  llr_t         llr [N],
    input  logic [0:N-1] frozen,
    output logic [0:N-1] u_hat
);

    // Size-4 SC subtree: decide four leaves in order from four LLRs
    function automatic logic [0:3] dec4(input llr_t a0, input llr_t a1, input llr_t a2,
                                        input llr_t a3, input logic [0:3] frz);
        llr_t       b0, b1, c0, c1;
        logic [0:3] u;
        b0   = polar_f(a0, a2);
        b1   = polar_f(a1, a3);
        u[0] = !frz[0] && polar_f(b0, b1) < 0;
        u[1] = !frz[1] && polar_g(b0, b1, u[0]) < 0;
        c0   = polar_g(a0, a2, u[0] ^ u[1]);
        c1   = polar_g(a1, a3, u[1]);
        u[2] = !frz[2] && polar_f(c0, c1) < 0;
        u[3] = !frz[3] && polar_g(c0, c1, u[2]) < 0;
        return u;
    endfunction

    function automatic logic [0:3] enc4(input logic [0:3] u);
        return {u[0] ^ u[1] ^ u[2] ^ u[3], u[1] ^ u[3], u[2] ^ u[3], u[3]};
    endfunction

    llr_t       left  [4];
    llr_t       right [4];
    logic [0:3] u_l;
    logic [0:3] u_r;
    logic [0:3] ps;

    // Left half first, then right half using the left half's partial sums
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            left[i] = polar_f(llr[i], llr[i+4]);
        end
        u_l = dec4(left[0], left[1], left[2], left[3], frozen[0:3]);
        ps  = enc4(u_l);
        for (int i = 0; i < 4; i++) begin
            right[i] = polar_g(llr[i], llr[i+4], ps[i]);
        end
        u_r   = dec4(right[0], right[1], right[2], right[3], frozen[4:7]);
        u_hat = {u_l, u_r};
    end

endmodule

// File: rtl/polar_sc_codec_n8.sv
// N=8 polar encode -> BPSK -> SC decode loopback pipeline, two register stages.
module polar_sc_codec_n8
    import polar_pkg::*;
#(
    parameter int unsigned K    = 4,
    parameter int unsigned SIZE = SYM_W,
    parameter int          AMP  = 1
) (
    input logic                clk,
    input logic                rst_n,
    polar_sc_codec_n8_if.slave bus
);

    localparam int unsigned     KW      = (K > 1) ? $clog2(K) : 1;
    localparam logic [N-1:0]    MASK    = info_mask(K);
    localparam logic [0:N-1]    FROZEN  = ~MASK;
    localparam logic [SIZE-1:0] SYM_POS = SIZE'(AMP);
    localparam logic [SIZE-1:0] SYM_NEG = SIZE'(-AMP);

    logic [0:N-1]      u_c, cw_c, uh_c;
    logic [N*SIZE-1:0] sym_c, llr_sel_c;
    logic [0:K-1]      info_c;
    llr_t              dec_llr [N];

    logic              v1_q, v2_q;
    logic [0:N-1]      cw1_q, cw2_q, uh2_q;
    logic [N*SIZE-1:0] sym1_q, sym2_q, llr1_q;
    logic [0:K-1]      info2_q;

    // Place message bits in ascending information positions, encode and map
    always_comb begin
        int unsigned cnt;
        u_c = '0;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (MASK[N-1-i] && cnt < K) begin
                u_c[i] = bus.info_i[KW'(cnt)];
                cnt    = cnt + 1;
            end
        end
        cw_c  = encode(u_c);
        sym_c = '0;
        for (int j = 0; j < N; j++) begin
            sym_c[(N-j)*SIZE-1 -: SIZE] = cw_c[j] ? SYM_NEG : SYM_POS;
        end
        llr_sel_c = bus.llr_ext_en ? bus.llr_ext_i : sym_c;
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            dec_llr[j] = LLR_W'($signed(llr1_q[(N-j)*SIZE-1 -: SIZE]));
        end
    end

    polar_sc_dec8 u_dec (
        .llr    (dec_llr),
        .frozen (FROZEN),
        .u_hat  (uh_c)
    );

    always_comb begin
        int unsigned cnt;
        info_c = '0;
        cnt    = 0;
        for (int i = 0; i < N; i++) begin
            if (MASK[N-1-i] && cnt < K) begin
                info_c[KW'(cnt)] = uh_c[i];
                cnt              = cnt + 1;
            end
        end
    end

    // Stage 1 captures on in_valid, stage 2 captures when stage 1 holds new data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            cw1_q   <= '0;
            sym1_q  <= '0;
            llr1_q  <= '0;
            cw2_q   <= '0;
            sym2_q  <= '0;
            uh2_q   <= '0;
            info2_q <= '0;
        end else begin
            v1_q <= bus.in_valid;
            v2_q <= v1_q;
            if (bus.in_valid) begin
                cw1_q  <= cw_c;
                sym1_q <= sym_c;
                llr1_q <= llr_sel_c;
            end
            if (v1_q) begin
                cw2_q   <= cw1_q;
                sym2_q  <= sym1_q;
                uh2_q   <= uh_c;
                info2_q <= info_c;
            end
        end
    end

    assign bus.codeword_o = cw2_q;
    assign bus.sym_o      = sym2_q;
    assign bus.u_hat_o    = uh2_q;
    assign bus.info_o     = info2_q;
    assign bus.out_valid  = v2_q;

endmodule

// File: tb/tb_polar_sc_codec_n8.sv
// Scoreboard bench: K=4 and K=1 codecs driven in lockstep against a tree-walk SC reference model.
module tb_polar_sc_codec_n8;

    localparam int unsigned SIZE = 8;

    typedef struct packed {
        logic [0:7]  cw;
        logic [63:0] sym;
        logic [0:7]  uh;
        logic [0:3]  info;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic drive_valid;
    logic [1:0] vhist;
    exp_t q4[$];
    exp_t q1[$];
    exp_t last4, last1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    polar_sc_codec_n8_if #(.K(4), .SIZE(SIZE)) bus4 ();
    polar_sc_codec_n8_if #(.K(1), .SIZE(SIZE)) bus1 ();

    polar_sc_codec_n8 #(.K(4), .SIZE(SIZE), .AMP(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    polar_sc_codec_n8 #(.K(1), .SIZE(SIZE), .AMP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    function automatic int fmin(input int a, input int b);
        int ma, mb, m;
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        m  = (ma < mb) ? ma : mb;
        return ((a < 0) != (b < 0)) ? -m : m;
    endfunction

    // Reference: generator matrix as a Kronecker power, SC as a walk down the decoding tree
    function automatic exp_t model(input int k, input logic [0:3] info, input logic ext_en,
                                   input logic [63:0] ext);
        exp_t e;
        int   pos[4];
        int   u[8], x[8], uh[8], alpha[4][8];
        bit   info_set[8];
        int   g, s, t, base, a, b, beta;
        e = '0;
        case (k)
            1:       pos = '{7, 0, 0, 0};
            2:       pos = '{6, 7, 0, 0};
            3:       pos = '{5, 6, 7, 0};
            default: pos = '{3, 5, 6, 7};
        endcase
        for (int i = 0; i < 8; i++) begin
            u[i] = 0;
            info_set[i] = 0;
            uh[i] = 0;
        end
        for (int n = 0; n < k; n++) begin
            u[pos[n]] = int'(info[n]);
            info_set[pos[n]] = 1;
        end
        for (int j = 0; j < 8; j++) begin
            x[j] = 0;
            for (int i = 0; i < 8; i++) begin
                g = 1;
                for (int bt = 0; bt < 3; bt++)
                    if (((i >> bt) & 1) == 0 && ((j >> bt) & 1) == 1) g = 0;
                x[j] = x[j] ^ (u[i] & g);
            end
            e.cw[j] = x[j][0];
            e.sym[(8-j)*8-1 -: 8] = (x[j] != 0) ? 8'hFF : 8'h01;
            if (ext_en) alpha[0][j] = int'($signed(ext[(8-j)*8-1 -: 8]));
            else        alpha[0][j] = (x[j] != 0) ? -1 : 1;
        end
        for (int i = 0; i < 8; i++) begin
            for (int d = 1; d <= 3; d++) begin
                s = 8 >> d;
                t = i >> (3 - d);
                base = (t >> 1) * 2 * s;
                for (int kk = 0; kk < s; kk++) begin
                    a = alpha[d-1][base+kk];
                    b = alpha[d-1][base+s+kk];
                    if ((t & 1) == 0) begin
                        alpha[d][t*s+kk] = fmin(a, b);
                    end else begin
                        beta = 0;
                        for (int m = 0; m < s; m++)
                            if ((m & kk) == kk) beta = beta ^ uh[(t-1)*s+m];
                        alpha[d][t*s+kk] = (beta != 0) ? b - a : b + a;
                    end
                end
            end
            uh[i] = (info_set[i] && alpha[3][i] < 0) ? 1 : 0;
            e.uh[i] = uh[i][0];
        end
        for (int n = 0; n < k; n++) e.info[n] = uh[pos[n]][0];
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t act, input exp_t exp, input int k);
        logic [0:3] m;
        for (int n = 0; n < 4; n++) m[n] = (n < k);
        chk({tag, " codeword"}, 64'(act.cw), 64'(exp.cw));
        chk({tag, " sym"}, act.sym, exp.sym);
        chk({tag, " u_hat"}, 64'(act.uh), 64'(exp.uh));
        chk({tag, " info"}, 64'(act.info & m), 64'(exp.info & m));
    endtask

    // Bench-side image of in_valid delayed two cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vhist <= 2'b00;
        else        vhist <= {vhist[0], drive_valid};
    end

    always @(negedge clk) begin
        exp_t a4, a1, e;
        a4 = '{cw: bus4.codeword_o, sym: bus4.sym_o, uh: bus4.u_hat_o, info: bus4.info_o};
        a1 = '{cw: bus1.codeword_o, sym: bus1.sym_o, uh: bus1.u_hat_o, info: {bus1.info_o, 3'b000}};
        if (!rst_n) begin
            last4 = '0;
            last1 = '0;
        end
        chk("k4 out_valid", 64'(bus4.out_valid), 64'(vhist[1]));
        chk("k1 out_valid", 64'(bus1.out_valid), 64'(vhist[1]));
        if (rst_n && bus4.out_valid) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL k4 scoreboard: output with no expected entry at %0t", $time);
            end else begin
                e = q4.pop_front();
                cmp("k4", a4, e, 4);
                last4 = e;
            end
        end else cmp("k4 hold", a4, last4, 4);
        if (rst_n && bus1.out_valid) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL k1 scoreboard: output with no expected entry at %0t", $time);
            end else begin
                e = q1.pop_front();
                cmp("k1", a1, e, 1);
                last1 = e;
            end
        end else cmp("k1 hold", a1, last1, 1);
    end

    task automatic send(input logic [0:3] info, input logic ext_en, input logic [63:0] ext);
        @(posedge clk); #1;
        bus4.in_valid = 1'b1; bus4.info_i = info;    bus4.llr_ext_en = ext_en; bus4.llr_ext_i = ext;
        bus1.in_valid = 1'b1; bus1.info_i = info[0]; bus1.llr_ext_en = ext_en; bus1.llr_ext_i = ext;
        drive_valid = 1'b1;
        q4.push_back(model(4, info, ext_en, ext));
        q1.push_back(model(1, {info[0], 3'b000}, ext_en, ext));
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        drive_valid   = 1'b0;
    endtask

    function automatic logic [63:0] noisy(input logic [0:7] cw);
        logic [63:0] r;
        int v;
        for (int j = 0; j < 8; j++) begin
            v = (cw[j] ? -4 : 4) + int'($urandom_range(0, 8)) - 4;
            r[(8-j)*8-1 -: 8] = 8'(v);
        end
        return r;
    endfunction

    initial begin
        logic [0:3]  info;
        logic [63:0] ext;
        rst_n = 1'b0;
        drive_valid = 1'b0;
        bus4.in_valid = 1'b0; bus4.info_i = '0; bus4.llr_ext_en = 1'b0; bus4.llr_ext_i = '0;
        bus1.in_valid = 1'b0; bus1.info_i = '0; bus1.llr_ext_en = 1'b0; bus1.llr_ext_i = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        idle();

        send(4'b0001, 1'b0, '0);
        send(4'b1000, 1'b0, '0);
        send(4'b1111, 1'b0, '0);
        send(4'b0000, 1'b0, '0);
        send(4'b0001, 1'b1, {8'h04, {7{8'hFC}}});
        send(4'b1011, 1'b1, '0);
        idle();
        for (int m = 0; m < 16; m++) send(4'(m), 1'b0, '0);
        send(4'b0110, 1'b0, '0);
        idle();
        send(4'b1001, 1'b0, '0);
        idle();
        idle();

        repeat (150) begin
            if ($urandom_range(0, 3) == 0) idle();
            else begin
                info = 4'($urandom_range(0, 15));
                case ($urandom_range(0, 2))
                    0:       send(info, 1'b0, '0);
                    1:       send(info, 1'b1, noisy(model(4, info, 1'b0, '0).cw));
                    default: begin
                        ext = {$urandom, $urandom};
                        send(info, 1'b1, ext);
                    end
                endcase
            end
        end

        // Reset while the pipeline is full: out_valid must drop without a clock edge
        send(4'b0101, 1'b0, '0);
        send(4'b1110, 1'b0, '0);
        send(4'b0011, 1'b0, '0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus1.in_valid = 1'b0; drive_valid = 1'b0;
        q4.delete();
        q1.delete();
        #1;
        chk("k4 async reset out_valid", 64'(bus4.out_valid), 64'd0);
        chk("k1 async reset out_valid", 64'(bus1.out_valid), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        for (int n = 0; n < 10; n++) begin
            info = 4'($urandom_range(0, 15));
            send(info, 1'b1, noisy(model(4, info, 1'b0, '0).cw));
        end
        idle();
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (q4.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expected results never appeared", q4.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
